mcp_controller: RTL
===================

Name: mcp_controller

Overview:
- Control unit for the multicycle RISC-V processor datapath (rv32i subset: lw, sw, R-type, I-type ALU, beq, jal).
- Sequences the shared memory, ALU and register file through a Moore main FSM, with combinational ALU and immediate decoders.
- Sits inside the processor next to the datapath, which feeds back the instruction fields and the ALU zero flag.

Parameters:
- none (fixed rv32i subset; ALU encodings below are fixed)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- op  input  7  instruction opcode, instr[6:0], from the instruction register
- funct3  input  3  instr[14:12]
- funct7b5  input  1  instr[30]
- zero  input  1  ALU zero flag
- pc_write  output  1  PC register enable
- adr_src  output  1  memory address select: 0=PC, 1=result
- mem_write  output  1  memory write enable
- ir_write  output  1  instruction/old-PC register enable
- reg_write  output  1  register file write enable
- result_src  output  2  00=ALUOut, 01=Data, 10=ALUResult
- alu_src_a  output  2  00=PC, 01=OldPC, 10=rs1 data
- alu_src_b  output  2  00=rs2 data, 01=ImmExt, 10=constant 4
- imm_src  output  2  00=I, 01=S, 10=B, 11=J
- alu_control  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- state_dbg  output  4  current FSM state encoding

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10. Codes 11-15 are unreachable; if entered, the next state is FETCH.
- Transitions:
  - FETCH->DECODE.
  - DECODE: op 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1101111 -> JAL; 1100011 -> BEQ; any other op -> FETCH (illegal opcode, no side effects).
  - MEMADR: op 0000011 -> MEMREAD, otherwise -> MEMWRITE.
  - MEMREAD->MEMWB->FETCH. MEMWRITE->FETCH.
  - EXECUTER, EXECUTEI, JAL -> ALUWB. ALUWB->FETCH. BEQ->FETCH.
- Instruction latency in cycles, FETCH inclusive: lw 5, sw 4, R 4, I 4, jal 4, beq 3.
- Moore outputs per state. Unlisted signals are 0 and alu_op=00.
  - FETCH: adr_src 0, ir_write 1, alu_src_a 00, alu_src_b 10, result_src 10, pc_update 1.
  - DECODE: alu_src_a 01, alu_src_b 01 (branch target into ALUOut).
  - MEMADR: alu_src_a 10, alu_src_b 01.
  - MEMREAD: result_src 00, adr_src 1.
  - MEMWB: result_src 01, reg_write 1.
  - MEMWRITE: result_src 00, adr_src 1, mem_write 1.
  - EXECUTER: alu_src_a 10, alu_src_b 00, alu_op 10.
  - EXECUTEI: alu_src_a 10, alu_src_b 01, alu_op 10.
  - ALUWB: result_src 00, reg_write 1.
  - JAL: alu_src_a 01, alu_src_b 10, result_src 00, pc_update 1.
  - BEQ: alu_src_a 10, alu_src_b 00, alu_op 01, result_src 00, branch 1.
- pc_write = pc_update | (branch & zero). zero is sampled combinationally in BEQ only.
- imm_src is decoded from op in every state: 0000011/0010011 -> 00; 0100011 -> 01; 1100011 -> 10; 1101111 -> 11; other -> 00.
- ALU decoder:
  - alu_op 00 -> add; 01 -> sub.
  - alu_op 10, by funct3:
    - 000: sub if (op[5] & funct7b5), else add. addi with instr[30]=1 stays add.
    - 010 -> slt; 110 -> or; 111 -> and.
    - any other funct3 -> add.
- Reset:
  - reset high at a rising edge -> state=FETCH on the next cycle, overriding any state.
  - While reset is high, pc_write, ir_write, reg_write and mem_write are forced to 0. Other outputs follow the current state.
  - Reset mid-instruction aborts it with no further writes.
- No combinational path from zero to anything except pc_write. No latches; all decode fully specified.

Test Plan:
- Reset held 2 cycles, released -> state_dbg=0, ir_write=1, pc_write=1, alu_src_b=10, result_src=10, mem_write=0, reg_write=0; enables 0 while reset high.
- lw (op=0000011) -> state_dbg 0,1,2,3,4,0. reg_write=1 only in state 4 with result_src=01. adr_src=1 in state 3. mem_write never 1.
- sw (op=0100011) -> states 0,1,2,5,0. mem_write=1 exactly one cycle (state 5) with adr_src=1. imm_src=01 throughout.
- beq (op=1100011): zero=1 -> pc_write=1 in state 10, alu_control=001, imm_src=10. Repeat with zero=0 -> pc_write=0 in state 10. Both return to FETCH after 3 cycles.
- R-type sub (op=0110011, funct3=000, funct7b5=1) -> alu_control=001 in state 6, then reg_write=1 in state 7. addi (op=0010011, funct3=000, funct7b5=1) -> alu_control=000 in state 8. or (funct3=110) -> 011. slt (funct3=010) -> 101.
- Illegal op=0000000 -> DECODE then FETCH, no write enables. Reset asserted in MEMADR for a sw -> mem_write never asserts, state_dbg=0 next cycle.

Source files
------------

// File: rtl/mcp_controller.sv
// Control unit for a multicycle rv32i-subset datapath: Moore main FSM plus
// combinational immediate-select and ALU decoders.
module mcp_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] imm_src,
   output logic [2:0] alu_control,
   output logic [3:0] state_dbg
);

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECUTEI = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10
   } state_t;

   state_t state_reg;
   state_t state_next;

   logic       pc_update;
   logic       branch;
   logic       ir_write_raw;
   logic       reg_write_raw;
   logic       mem_write_raw;
   logic [1:0] alu_op;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= S_FETCH;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = S_FETCH;
      case (state_reg)
         S_FETCH:    state_next = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_next = S_MEMADR;
               OP_R:         state_next = S_EXECUTER;
               OP_I:         state_next = S_EXECUTEI;
               OP_JAL:       state_next = S_JAL;
               OP_BEQ:       state_next = S_BEQ;
               default:      state_next = S_FETCH;
            endcase
         end
         S_MEMADR:   state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_next = S_MEMWB;
         S_MEMWB:    state_next = S_FETCH;
         S_MEMWRITE: state_next = S_FETCH;
         S_EXECUTER: state_next = S_ALUWB;
         S_EXECUTEI: state_next = S_ALUWB;
         S_JAL:      state_next = S_ALUWB;
         S_ALUWB:    state_next = S_FETCH;
         S_BEQ:      state_next = S_FETCH;
         default:    state_next = S_FETCH;
      endcase
   end

   // Moore outputs: everything here depends on the state alone.
   always_comb begin
      pc_update     = 1'b0;
      branch        = 1'b0;
      ir_write_raw  = 1'b0;
      reg_write_raw = 1'b0;
      mem_write_raw = 1'b0;
      adr_src       = 1'b0;
      result_src    = RES_ALUOUT;
      alu_src_a     = SRCA_PC;
      alu_src_b     = SRCB_RS2;
      alu_op        = 2'b00;
      case (state_reg)
         S_FETCH: begin
            ir_write_raw = 1'b1;
            alu_src_a    = SRCA_PC;
            alu_src_b    = SRCB_FOUR;
            result_src   = RES_ALURESULT;
            pc_update    = 1'b1;
         end
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
         end
         S_MEMREAD: begin
            result_src = RES_ALUOUT;
            adr_src    = 1'b1;
         end
         S_MEMWB: begin
            result_src    = RES_DATA;
            reg_write_raw = 1'b1;
         end
         S_MEMWRITE: begin
            result_src    = RES_ALUOUT;
            adr_src       = 1'b1;
            mem_write_raw = 1'b1;
         end
         S_EXECUTER: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_RS2;
            alu_op    = 2'b10;
         end
         S_EXECUTEI: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_op    = 2'b10;
         end
         S_ALUWB: begin
            result_src    = RES_ALUOUT;
            reg_write_raw = 1'b1;
         end
         S_JAL: begin
            alu_src_a  = SRCA_OLDPC;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALUOUT;
            pc_update  = 1'b1;
         end
         S_BEQ: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_RS2;
            alu_op     = 2'b01;
            result_src = RES_ALUOUT;
            branch     = 1'b1;
         end
         default: begin
            pc_update = 1'b0;
         end
      endcase
   end

   // Reset suppresses every architectural write; zero only reaches pc_write.
   assign pc_write  = ~reset & (pc_update | (branch & zero));
   assign ir_write  = ~reset & ir_write_raw;
   assign reg_write = ~reset & reg_write_raw;
   assign mem_write = ~reset & mem_write_raw;
   assign state_dbg = state_reg;

   always_comb begin
      imm_src = 2'b00;
      case (op)
         OP_LW, OP_I: imm_src = 2'b00;
         OP_SW:       imm_src = 2'b01;
         OP_BEQ:      imm_src = 2'b10;
         OP_JAL:      imm_src = 2'b11;
         default:     imm_src = 2'b00;
      endcase
   end

   // op[5] separates R-type from I-type, so addi with instr[30] set stays add.
   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         2'b00: alu_control = ALU_ADD;
         2'b01: alu_control = ALU_SUB;
         2'b10: begin
            case (funct3)
               3'b000:  alu_control = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule
